// File: rtl/conv_mac_pipe.sv
// Pipelined KxK convolution MAC: multiply, adder-tree and post-process stages.
// Valid/ready flow control between the stages; each window's shift_amt and abs_mode travel with it.
module conv_mac_pipe #(
  parameter int IMAGE_WIDTH  = 8,
  parameter int KERNEL_WIDTH = 5,
  parameter int MATRIX_SIZE  = 3,
  parameter int SHIFT_WIDTH  = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [IMAGE_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]    in_matrix,
  input  logic [KERNEL_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]   kernel,
  input  logic [SHIFT_WIDTH-1:0]                            shift_amt,
  input  logic                                              abs_mode,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [IMAGE_WIDTH-1:0]                            conv_res,
  output logic                                              sat_flag,
  output logic [CNT_WIDTH-1:0]                              out_count
);

  localparam int TAPS      = MATRIX_SIZE * MATRIX_SIZE;
  localparam int MUL_WIDTH = IMAGE_WIDTH + KERNEL_WIDTH + 1;
  localparam int ACC_WIDTH = MUL_WIDTH + $clog2(TAPS);

  logic signed [MUL_WIDTH-1:0] w_prod [TAPS];
  logic signed [MUL_WIDTH-1:0] r_prod [TAPS];
  logic                        r_s1_valid;
  logic [SHIFT_WIDTH-1:0]      r_s1_shift;
  logic                        r_s1_abs;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_s2_sum;
  logic                        r_s2_valid;
  logic [SHIFT_WIDTH-1:0]      r_s2_shift;
  logic                        r_s2_abs;

  logic signed [ACC_WIDTH:0]   w_half;
  logic signed [ACC_WIDTH:0]   w_rnd;
  logic signed [ACC_WIDTH:0]   w_shr;
  logic signed [ACC_WIDTH:0]   w_mag;
  logic                        w_sat;
  logic [IMAGE_WIDTH-1:0]      w_res;

  logic                        r_out_valid;
  logic [IMAGE_WIDTH-1:0]      r_conv_res;
  logic                        r_sat_flag;
  logic [CNT_WIDTH-1:0]        r_count;

  logic                        w_s3_ready;
  logic                        w_s2_ready;
  logic                        w_in_ready;

  // A stage may load when it is empty or its current contents move on this cycle.
  assign w_s3_ready = !r_out_valid || out_ready;
  assign w_s2_ready = !r_s2_valid || w_s3_ready;
  assign w_in_ready = !r_s1_valid || w_s2_ready;

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_prod[i] = $signed(MUL_WIDTH'({1'b0, in_matrix[i*IMAGE_WIDTH +: IMAGE_WIDTH]}))
                * $signed(MUL_WIDTH'($signed(kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH])));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_shift <= '0;
      r_s1_abs   <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_shift <= shift_amt;
        r_s1_abs   <= abs_mode;
        for (int i = 0; i < TAPS; i++) r_prod[i] <= w_prod[i];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) w_sum = w_sum + ACC_WIDTH'(r_prod[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_shift <= '0;
      r_s2_abs   <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum   <= w_sum;
        r_s2_shift <= r_s1_shift;
        r_s2_abs   <= r_s1_abs;
      end
    end
  end

  // Round half up with one guard bit, then resolve sign and clamp to the pixel range.
  always_comb begin
    if (r_s2_shift != '0) begin
      w_half = $signed((ACC_WIDTH+1)'(1'b1) << (r_s2_shift - SHIFT_WIDTH'(1'b1)));
    end else begin
      w_half = '0;
    end
    w_rnd = $signed((ACC_WIDTH+1)'(r_s2_sum)) + w_half;
    w_shr = w_rnd >>> r_s2_shift;
    if (w_shr[ACC_WIDTH]) begin
      w_mag = r_s2_abs ? -w_shr : '0;
    end else begin
      w_mag = w_shr;
    end
    w_sat = |w_mag[ACC_WIDTH:IMAGE_WIDTH];
    w_res = w_sat ? '1 : w_mag[IMAGE_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_conv_res  <= '0;
      r_sat_flag  <= 1'b0;
    end else if (w_s3_ready) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_conv_res <= w_res;
        r_sat_flag <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_count <= r_count + CNT_WIDTH'(1'b1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign conv_res  = r_conv_res;
  assign sat_flag  = r_sat_flag;
  assign out_count = r_count;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: an arithmetic reference model feeds a result queue that
// a negedge monitor compares against two instances (default and 4-bit out_count).
module tb_conv_mac_pipe;

  localparam int IW = 8;
  localparam int KW = 5;
  localparam int T  = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW*T-1:0] in_matrix = '0;
  logic [KW*T-1:0] kernel = '0;
  logic [3:0]    shift_amt = 4'd0;
  logic          abs_mode = 1'b0;

  logic          in_ready, out_valid, sat_flag;
  logic [7:0]    conv_res;
  logic [15:0]   out_count;
  logic          in_ready2, out_valid2, sat_flag2;
  logic [7:0]    conv_res2;
  logic [3:0]    out_count2;

  conv_mac_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_matrix(in_matrix), .kernel(kernel), .shift_amt(shift_amt), .abs_mode(abs_mode),
    .out_valid(out_valid), .out_ready(out_ready), .conv_res(conv_res),
    .sat_flag(sat_flag), .out_count(out_count)
  );

  conv_mac_pipe #(.CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_matrix(in_matrix), .kernel(kernel), .shift_amt(shift_amt), .abs_mode(abs_mode),
    .out_valid(out_valid2), .out_ready(out_ready), .conv_res(conv_res2),
    .sat_flag(sat_flag2), .out_count(out_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit sat;
  } exp_t;

  exp_t q[$];
  int   mcount = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic exp_t model(input logic [IW*T-1:0] m, input logic [KW*T-1:0] k,
                                 input int sh, input bit ab);
    longint s;
    exp_t   e;
    s = 0;
    for (int i = 0; i < T; i++)
      s += longint'(m[i*IW +: IW]) * longint'($signed(k[i*KW +: KW]));
    if (sh > 0) s += longint'(1) << (sh - 1);
    s = s >>> sh;
    if (s < 0) s = ab ? -s : 0;
    e.sat = (s > 255);
    e.res = e.sat ? 255 : int'(s);
    return e;
  endfunction

  function automatic logic [IW*T-1:0] pfill(input int v);
    logic [IW*T-1:0] r;
    for (int i = 0; i < T; i++) r[i*IW +: IW] = 8'(v);
    return r;
  endfunction

  function automatic logic [IW*T-1:0] pcenter(input int v);
    logic [IW*T-1:0] r;
    r = '0;
    r[4*IW +: IW] = 8'(v);
    return r;
  endfunction

  function automatic logic [KW*T-1:0] kfill(input int v);
    logic [KW*T-1:0] r;
    for (int i = 0; i < T; i++) r[i*KW +: KW] = 5'(v);
    return r;
  endfunction

  function automatic logic [KW*T-1:0] kcenter(input int v);
    logic [KW*T-1:0] r;
    r = '0;
    r[4*KW +: KW] = 5'(v);
    return r;
  endfunction

  function automatic logic [KW*T-1:0] kgauss();
    int g[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    logic [KW*T-1:0] r;
    for (int i = 0; i < T; i++) r[i*KW +: KW] = 5'(g[i]);
    return r;
  endfunction

  // Monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcount = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_count_w4", out_count2, 0);
    end else begin
      check("out_count", out_count, mcount % 65536);
      check("out_count_w4", out_count2, mcount % 16);
      check("out_valid_pair", out_valid2, out_valid);
      check("in_ready_pair", in_ready2, in_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          check("conv_res", conv_res, q[0].res);
          check("sat_flag", sat_flag, q[0].sat);
          check("conv_res_w4", conv_res2, q[0].res);
          check("sat_flag_w4", sat_flag2, q[0].sat);
          if (out_ready) begin
            void'(q.pop_front());
            mcount++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_matrix, kernel, int'(shift_amt), abs_mode));
    end
  end

  task automatic send(input logic [IW*T-1:0] m, input logic [KW*T-1:0] k,
                      input logic [3:0] sh, input logic ab);
    bit acc;
    acc = 1'b0;
    in_matrix = m; kernel = k; shift_amt = sh; abs_mode = ab; in_valid = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    check("drain_timeout", done, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_count", out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   c0;

    // Pin the reference model to hand-computed results.
    e = model(pfill(10), kfill(1), 0, 1'b0);     check("pin_sum90", e.res, 90);
    e = model(pfill(255), kgauss(), 4, 1'b0);    check("pin_gauss", e.res, 255);
                                                 check("pin_gauss_sat", e.sat, 0);
    e = model(pcenter(24), kcenter(1), 4, 1'b0); check("pin_round", e.res, 2);
    e = model(pfill(20), kfill(-1), 0, 1'b0);    check("pin_neg0", e.res, 0);
                                                 check("pin_neg0_sat", e.sat, 0);
    e = model(pfill(20), kfill(-1), 0, 1'b1);    check("pin_abs", e.res, 180);
    e = model(pfill(255), kfill(-16), 0, 1'b1);  check("pin_abs_sat", e.sat, 1);
    e = model(pfill(255), kfill(15), 0, 1'b0);   check("pin_pos_sat", e.res, 255);
    e = model(pfill(20), kfill(-1), 3, 1'b1);    check("pin_neg_round", e.res, 22);

    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: out_valid rises on the third cycle after acceptance.
    send(pfill(10), kfill(1), 4'd0, 1'b0);
    @(negedge clk); check("lat_c1", out_valid, 0);
    @(negedge clk); check("lat_c2", out_valid, 0);
    @(negedge clk); check("lat_c3", out_valid, 1);
    check("lat_res", conv_res, 90);
    drain();

    send(pfill(255), kgauss(), 4'd4, 1'b0);
    send(pcenter(24), kcenter(1), 4'd4, 1'b0);
    send(pfill(20), kfill(-1), 4'd0, 1'b0);
    send(pfill(20), kfill(-1), 4'd0, 1'b1);
    send(pfill(255), kfill(-16), 4'd0, 1'b1);
    send(pfill(255), kfill(15), 4'd0, 1'b0);
    send(pfill(20), kfill(-1), 4'd3, 1'b1);
    send(pcenter(1), kcenter(1), 4'd15, 1'b0);
    send(pfill(200), kfill(-16), 4'd15, 1'b0);
    drain();

    // Backpressure: three windows fill the pipe, then in_ready drops until release.
    do_reset();
    out_ready = 1'b0;
    send(pfill(1), kfill(1), 4'd0, 1'b0);
    send(pfill(2), kfill(1), 4'd0, 1'b0);
    send(pfill(3), kfill(1), 4'd0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_held_res", conv_res, 9);
    @(posedge clk); #1;
    fork
      begin
        send(pfill(4), kfill(1), 4'd0, 1'b0);
        send(pfill(5), kfill(1), 4'd0, 1'b0);
        send(pfill(6), kfill(1), 4'd0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", out_count, 6);

    // Reset with two windows in flight; only the next window's result may appear.
    send(pfill(9), kfill(1), 4'd0, 1'b0);
    send(pfill(8), kfill(1), 4'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(pfill(7), kfill(1), 4'd0, 1'b0);
    drain();
    check("post_rst_count", out_count, 1);

    // Wrap of the 4-bit counter and full-rate streaming.
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 17; i++) send(pcenter(i + 1), kcenter(1), 4'd0, 1'b0);
    check("stream_cycles", cyc - c0, 17);
    drain();
    check("wrap_count16", out_count, 17);
    check("wrap_count4", out_count2, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", total_cnt);
    $fatal(1);
  end

endmodule
